// File: rtl/sap_clk_pkg.sv
// rtl/sap_clk_pkg.sv - shared state encoding and defaults for the SAP-1 clock controller
package sap_clk_pkg;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } clk_state_e;

  localparam int DEFAULT_RUN_DIV = 5_000_000;

endpackage

// File: rtl/sap_clk_divider.sv
// rtl/sap_clk_divider.sv - run-mode divider, ticks and wraps at RUN_DIV-1
module sap_clk_divider #(
  parameter int RUN_DIV   = 5_000_000,
  parameter int DIV_WIDTH = 24
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic sclr,
  output logic tick
);

  localparam logic [DIV_WIDTH-1:0] TERM = DIV_WIDTH'(RUN_DIV - 1);

  logic [DIV_WIDTH-1:0] count;

  assign tick = (count == TERM);

  always_ff @(posedge clk) begin
    if (clr || sclr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/sap_clock_ctrl.sv
// rtl/sap_clock_ctrl.sv - manual/run/halt clock-enable generator for the SAP-1 core
module sap_clock_ctrl
  import sap_clk_pkg::*;
#(
  parameter int RUN_DIV   = DEFAULT_RUN_DIV,
  parameter int DIV_WIDTH = 24
) (
  input  logic clk,
  input  logic clr,
  input  logic step_pulse,
  input  logic mode_pulse,
  input  logic hlt,
  output logic cpu_ce,
  output logic run_mode,
  output logic halted,
  output logic cpu_clk_led
);

  clk_state_e state;
  clk_state_e state_next;
  logic       ce_next;
  logic       step_prev;
  logic       mode_prev;
  logic       step_ev;
  logic       mode_ev;
  logic       tick;
  logic       div_sclr;

  assign step_ev = step_pulse & ~step_prev;
  assign mode_ev = mode_pulse & ~mode_prev;

  // Divider restarts from zero on every mode switch so RUN always begins a full period.
  assign div_sclr = mode_ev && (state != HALTED);

  sap_clk_divider #(
    .RUN_DIV   (RUN_DIV),
    .DIV_WIDTH (DIV_WIDTH)
  ) u_divider (
    .clk  (clk),
    .clr  (clr),
    .en   (state == RUN),
    .sclr (div_sclr),
    .tick (tick)
  );

  always_comb begin
    state_next = state;
    ce_next    = 1'b0;
    case (state)
      MANUAL: begin
        if (hlt)          state_next = HALTED;
        else if (mode_ev) state_next = RUN;
        else if (step_ev) ce_next    = 1'b1;
      end
      RUN: begin
        if (hlt)          state_next = HALTED;
        else if (mode_ev) state_next = MANUAL;
        else if (tick)    ce_next    = 1'b1;
      end
      HALTED: state_next = HALTED;
      default: state_next = MANUAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= MANUAL;
      step_prev   <= 1'b0;
      mode_prev   <= 1'b0;
      cpu_ce      <= 1'b0;
      run_mode    <= 1'b0;
      halted      <= 1'b0;
      cpu_clk_led <= 1'b0;
    end else begin
      state       <= state_next;
      step_prev   <= step_pulse;
      mode_prev   <= mode_pulse;
      cpu_ce      <= ce_next;
      run_mode    <= (state_next == RUN);
      halted      <= (state_next == HALTED);
      cpu_clk_led <= cpu_clk_led ^ ce_next;
    end
  end

endmodule

// File: tb/tb_sap_clock_ctrl.sv
// tb/tb_sap_clock_ctrl.sv - directed and randomized bench for sap_clock_ctrl
module tb_sap_clock_ctrl;

  localparam int RUN_DIV = 4;

  logic clk = 1'b0;
  logic clr, step_pulse, mode_pulse, hlt;
  logic cpu_ce, run_mode, halted, cpu_clk_led;

  int tests = 0;
  int errors = 0;

  // reference model: 0 = manual, 1 = run, 2 = halted
  int m_state = 0;
  int edge_n = 0;
  int run_start = 0;
  bit m_ce = 0, m_led = 0, m_sp = 0, m_mp = 0;
  int ce_seen;

  always #5 clk = ~clk;

  sap_clock_ctrl #(.RUN_DIV(RUN_DIV), .DIV_WIDTH(8)) dut (
    .clk         (clk),
    .clr         (clr),
    .step_pulse  (step_pulse),
    .mode_pulse  (mode_pulse),
    .hlt         (hlt),
    .cpu_ce      (cpu_ce),
    .run_mode    (run_mode),
    .halted      (halted),
    .cpu_clk_led (cpu_clk_led)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit s, input bit m, input bit h, input bit c);
    bit sev, mev;
    if (c) begin
      m_state = 0; m_ce = 0; m_led = 0; m_sp = 0; m_mp = 0;
    end else begin
      sev = s && !m_sp;
      mev = m && !m_mp;
      m_sp = s;
      m_mp = m;
      m_ce = 0;
      if (m_state == 2) begin
      end else if (h) begin
        m_state = 2;
      end else if (mev) begin
        if (m_state == 0) begin
          m_state = 1;
          run_start = edge_n;
        end else begin
          m_state = 0;
        end
      end else if (m_state == 0) begin
        m_ce = sev;
      end else begin
        m_ce = (edge_n != run_start) && ((edge_n - run_start) % RUN_DIV == 0);
      end
      if (m_ce) m_led = !m_led;
    end
    edge_n++;
  endtask

  task automatic cycle(input bit s, input bit m, input bit h, input bit c);
    step_pulse = s;
    mode_pulse = m;
    hlt        = h;
    clr        = c;
    @(posedge clk);
    model_edge(s, m, h, c);
    #1;
    if (cpu_ce === 1'b1) ce_seen++;
    check("cpu_ce", cpu_ce, m_ce);
    check("run_mode", run_mode, m_state == 1);
    check("halted", halted, m_state == 2);
    check("cpu_clk_led", cpu_clk_led, m_led);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
  endtask

  initial begin
    bit hl, s, m, c;

    // reset and idle
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    ce_seen = 0;
    idle(20);
    check("idle_no_ce", ce_seen != 0, 1'b0);

    // manual single step, then a held step counts once
    cycle(1, 0, 0, 0);
    check("step_latency1", cpu_ce, 1'b1);
    check("step_led_on", cpu_clk_led, 1'b1);
    idle(2);
    ce_seen = 0;
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0);
    idle(2);
    check("held_step_one_ce", ce_seen == 1, 1'b1);
    check("held_step_led_off", cpu_clk_led, 1'b0);

    // run mode with steps injected
    cycle(0, 1, 0, 0);
    check("enter_run", run_mode, 1'b1);
    ce_seen = 0;
    for (int i = 0; i < 12; i++) cycle(i % 3 == 0, 0, 0, 0);
    check("run_three_ce", ce_seen == 3, 1'b1);
    check("run_ce_at_k12", cpu_ce, 1'b1);

    // mode event coinciding with terminal count
    idle(3);
    cycle(0, 1, 0, 0);
    check("mode_vs_tc_no_ce", cpu_ce, 1'b0);
    check("mode_vs_tc_manual", run_mode, 1'b0);

    // simultaneous step and mode in manual
    idle(1);
    cycle(1, 1, 0, 0);
    check("step_mode_no_ce", cpu_ce, 1'b0);
    check("step_mode_run", run_mode, 1'b1);

    // halt at the terminal-count edge, then ignore buttons
    idle(3);
    cycle(0, 0, 1, 0);
    check("halt_tc_no_ce", cpu_ce, 1'b0);
    check("halt_set", halted, 1'b1);
    ce_seen = 0;
    for (int i = 0; i < 50; i++) cycle(i % 2, i % 5 == 0, 1, 0);
    check("halt_sticky", halted, 1'b1);
    check("halt_no_ce", ce_seen != 0, 1'b0);

    // recovery: clr mid-run with divider at 2
    cycle(0, 0, 0, 1);
    cycle(0, 1, 0, 0);
    idle(2);
    cycle(0, 0, 0, 1);
    check("recover_manual", run_mode, 1'b0);
    check("recover_led", cpu_clk_led, 1'b0);
    cycle(1, 0, 0, 0);
    check("recover_step", cpu_ce, 1'b1);

    // randomized traffic
    hl = 0;
    for (int i = 0; i < 3000; i++) begin
      c = ($urandom_range(0, 199) == 0);
      if (c) hl = 0;
      else if (!hl && $urandom_range(0, 299) == 0) hl = 1;
      s = ($urandom_range(0, 3) == 0);
      m = ($urandom_range(0, 11) == 0);
      cycle(s, m, hl, c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
